// File: rtl/burst_mem_pkg.sv
`default_nettype none
// =====================================================================
// burst_mem_pkg : shared widths and FSM state type for the burst responder
// Revision 1.0
// =====================================================================
package burst_mem_pkg;
  localparam int BEAT_W     = 64;
  localparam int BEATS      = 4;
  localparam int LINE_W     = 256;
  localparam int OFFSET_W   = 5;
  localparam int BEAT_IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } bmr_state_t;
endpackage
`default_nettype wire

// File: rtl/burst_mem_array.sv
`default_nettype none
// =====================================================================
// burst_mem_array : line store with per-beat write and registered beat read
// Revision 1.0
// =====================================================================
module burst_mem_array
  import burst_mem_pkg::*;
#(
  parameter int DEPTH_LINES = 256
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [$clog2(DEPTH_LINES)-1:0] index,
  input  logic [BEAT_IDX_W-1:0]          beat_sel,
  input  logic                           we,
  input  logic                           re,
  input  logic [BEAT_W-1:0]              wdata,
  output logic [BEAT_W-1:0]              rdata
);

  // Contents start at zero and are never touched by reset.
  logic [BEATS-1:0][BEAT_W-1:0] mem [DEPTH_LINES] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) begin
      mem[index][beat_sel] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[index][beat_sel];
    end
  end

endmodule
`default_nettype wire

// File: rtl/burst_mem_responder.sv
`default_nettype none
// =====================================================================
// burst_mem_responder : 4-beat x 64-bit burst memory responder, fixed latency
// Revision 1.0
// =====================================================================
module burst_mem_responder
  import burst_mem_pkg::*;
#(
  parameter int LATENCY     = 2,
  parameter int DEPTH_LINES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       address_i,
  input  logic              read_i,
  input  logic              write_i,
  input  logic [BEAT_W-1:0] burst_i,
  output logic [BEAT_W-1:0] burst_o,
  output logic              resp_o
);

  localparam int IDX_W = $clog2(DEPTH_LINES);
  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(LATENCY - 1);
  localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BEATS - 1);

  bmr_state_t            state;
  logic [IDX_W-1:0]      idx;
  logic                  is_read;
  logic [LAT_W-1:0]      lat_cnt;
  logic [BEAT_IDX_W-1:0] beat;

  logic                  arr_we;
  logic                  arr_re;
  logic [BEAT_IDX_W-1:0] arr_beat;

  logic unused_addr;
  assign unused_addr = ^{address_i[OFFSET_W-1:0], address_i[31:OFFSET_W+IDX_W]};

  // Reads prefetch one beat ahead so burst_o lines up with resp_o;
  // writes land on the edge that closes each beat, unless reset hits that edge.
  always_comb begin
    arr_we   = 1'b0;
    arr_re   = 1'b0;
    arr_beat = '0;
    if (state == BURST && !is_read) begin
      arr_we   = !rst;
      arr_beat = beat;
    end else if (state == BURST && is_read) begin
      arr_re   = (beat != LAST_BEAT);
      arr_beat = beat + BEAT_IDX_W'(1);
    end else if (state == WAIT && lat_cnt == '0 && is_read) begin
      arr_re   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      resp_o  <= 1'b0;
      idx     <= '0;
      is_read <= 1'b0;
      lat_cnt <= '0;
      beat    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (read_i || write_i) begin
            idx     <= address_i[OFFSET_W +: IDX_W];
            is_read <= read_i;
            lat_cnt <= LAT_INIT;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            beat   <= '0;
            resp_o <= 1'b1;
            state  <= BURST;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        BURST: begin
          beat <= beat + BEAT_IDX_W'(1);
          if (beat == LAST_BEAT) begin
            resp_o <= 1'b0;
            state  <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  burst_mem_array #(
    .DEPTH_LINES(DEPTH_LINES)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .index   (idx),
    .beat_sel(arr_beat),
    .we      (arr_we),
    .re      (arr_re),
    .wdata   (burst_i),
    .rdata   (burst_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_burst_mem_responder.sv
`default_nettype none
// =====================================================================
// tb_burst_mem_responder : directed + random bursts against a line-array model
// Revision 1.0
// =====================================================================
module tb_burst_mem_responder;
  localparam int LATENCY = 2;
  localparam int DEPTH   = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address_i;
  logic        read_i;
  logic        write_i;
  logic [63:0] burst_i;
  logic [63:0] burst_o;
  logic        resp_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] model [DEPTH][4];

  always #5 clk = ~clk;

  burst_mem_responder #(
    .LATENCY    (LATENCY),
    .DEPTH_LINES(DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .address_i(address_i),
    .read_i   (read_i),
    .write_i  (write_i),
    .burst_i  (burst_i),
    .burst_o  (burst_o),
    .resp_o   (resp_o)
  );

  function automatic int line_of(input logic [31:0] a);
    return int'((a / 32) % DEPTH);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete burst. hold_beats: request held through that many beats
  // (0 = dropped right after accept, >=5 = left asserted for the caller).
  // rst_at_beat: beat index during which reset is raised (-1 = none).
  task automatic burst(input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [63:0] wd [4], input int hold_beats,
                       input int rst_at_beat, input string tag);
    int ln;
    ln = line_of(addr);
    @(negedge clk);
    address_i = addr;
    read_i    = rd;
    write_i   = wr;
    for (int k = 1; k <= LATENCY; k++) begin
      @(negedge clk);
      if (k == 1 && hold_beats == 0) begin
        read_i    = 1'b0;
        write_i   = 1'b0;
        address_i = $urandom;
      end
      check({tag, "_lat_resp"}, 64'(resp_o), 64'd0);
    end
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      check({tag, "_beat_resp"}, 64'(resp_o), 64'd1);
      if (rd) begin
        check({tag, "_rdata"}, burst_o, model[ln][b]);
        burst_i = {$urandom, $urandom};
      end else begin
        burst_i = wd[b];
      end
      if (hold_beats > 0 && b + 1 == hold_beats) begin
        read_i    = 1'b0;
        write_i   = 1'b0;
        address_i = $urandom;
      end
      if (b == rst_at_beat) begin
        rst = 1'b1;
        @(negedge clk);
        check({tag, "_rst_resp"}, 64'(resp_o), 64'd0);
        check({tag, "_rst_bo"}, burst_o, 64'd0);
        rst     = 1'b0;
        read_i  = 1'b0;
        write_i = 1'b0;
        return;
      end
      if (!rd) model[ln][b] = wd[b];
    end
    @(negedge clk);
    check({tag, "_done_resp"}, 64'(resp_o), 64'd0);
    if (rd) check({tag, "_hold_bo"}, burst_o, model[ln][3]);
  endtask

  initial begin
    logic [63:0] wd [4];
    logic [63:0] junk [4];
    int          highs;
    int          gap;
    logic [31:0] a;

    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < 4; j++) model[i][j] = '0;
    for (int j = 0; j < 4; j++) junk[j] = '0;

    rst = 1'b1; address_i = '0; read_i = 1'b0; write_i = 1'b0; burst_i = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_resp", 64'(resp_o), 64'd0);
    check("reset_bo", burst_o, 64'd0);
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resp_o) highs++;
    end
    check("idle_resp", 64'(highs), 64'd0);

    // Untouched line reads back as zero.
    burst(1'b1, 1'b0, 32'h1E0, junk, 0, -1, "zero_rd");

    wd = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
           64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    burst(1'b0, 1'b1, 32'h40, wd, 0, -1, "wr40");
    burst(1'b1, 1'b0, 32'h40, junk, 0, -1, "rd40");
    burst(1'b1, 1'b0, 32'h40, junk, 2, -1, "rd40_drop");
    @(negedge clk);
    check("no_retrigger", 64'(resp_o), 64'd0);

    burst(1'b1, 1'b0, 32'h5C, junk, 0, -1, "rd5c");
    burst(1'b1, 1'b0, 32'h2040, junk, 0, -1, "rd_alias");

    for (int j = 0; j < 4; j++) wd[j] = {$urandom, $urandom};
    burst(1'b0, 1'b1, 32'hA0, wd, 0, -1, "wrA0_old");
    wd = '{64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
           64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD};
    burst(1'b0, 1'b1, 32'hA0, wd, 0, 2, "wrA0_rst");
    @(negedge clk);
    burst(1'b1, 1'b0, 32'hA0, junk, 0, -1, "rdA0");

    // Read+write together: read wins; held request restarts after DONE+IDLE+latency.
    burst(1'b1, 1'b1, 32'h40, junk, 99, -1, "rw40");
    gap = 1;
    for (int i = 0; i < 20 && !resp_o; i++) begin
      @(negedge clk);
      if (!resp_o) gap++;
    end
    check("b2b_gap", 64'(gap), 64'(LATENCY + 2));
    for (int b = 0; b < 4; b++) begin
      if (b > 0) @(negedge clk);
      read_i = 1'b0; write_i = 1'b0;
      check("b2b_resp", 64'(resp_o), 64'd1);
      check("b2b_rdata", burst_o, model[2][b]);
    end
    @(negedge clk);
    check("b2b_done", 64'(resp_o), 64'd0);
    burst(1'b1, 1'b0, 32'h40, junk, 0, -1, "rd40_after_rw");

    for (int it = 0; it < 24; it++) begin
      a = ($urandom & 32'hFFFF_E01F) | (32'($urandom_range(0, 7)) << 5);
      if ($urandom_range(0, 1) == 1) begin
        for (int j = 0; j < 4; j++) wd[j] = {$urandom, $urandom};
        burst(1'b0, 1'b1, a, wd, 0, -1, "rnd_wr");
      end else begin
        burst(1'b1, 1'b0, a, junk, 0, -1, "rnd_rd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
